door_input_conditioner: RTL

//  Upstream front end of the garage door controller. Synchronises and debounces the raw wall button and both limit

---
 rtl/door_pkg.sv | 13 +
 rtl/sig_debounce.sv | 50 +++++
 rtl/door_input_conditioner.sv | 128 ++++++++++++
 3 files changed

// File: rtl/door_pkg.sv
// Shared encodings for the door input conditioner's button FSM.
// The BTN_LOCKOUT encoding is only used when DOOR_ACT_LOCKOUT_EN is defined.
package door_pkg;

    localparam int unsigned STATE_W = 3;

    typedef logic [STATE_W-1:0] btn_state_t;

    localparam btn_state_t BTN_IDLE    = 3'b001;
    localparam btn_state_t BTN_PRESSED = 3'b010;
    localparam btn_state_t BTN_LOCKOUT = 3'b100;

endpackage

// File: rtl/sig_debounce.sv
// One input channel: 2-flop synchroniser followed by a counting debouncer.
// The debounced level flips after DB_CYCLES consecutive disagreeing samples.
module sig_debounce #(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic din_raw,
    output logic dout
);

    if (DB_CYCLES < 2 || DB_CYCLES >= (2 ** CNT_W)) begin : g_bad_db
        $error("sig_debounce: DB_CYCLES out of range for CNT_W");
    end

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= din_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Any agreeing sample restarts the count, so short glitches never flip the level.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/door_input_conditioner.sv
// Front end of the garage door controller: debounced button/limit inputs, one activate pulse per press.
// Define DOOR_ACT_LOCKOUT_EN to add a post-pulse lockout window before the next press is accepted.
module door_input_conditioner
    import door_pkg::*;
#(
    parameter int unsigned DB_CYCLES      = 16,
    parameter int unsigned CNT_W          = 5,
    parameter int unsigned LOCKOUT_CYCLES = 64,
    parameter int unsigned LK_W           = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic up_lim_raw,
    input  logic dn_lim_raw,
    output logic activate,
    output logic UP_max,
    output logic DN_max,
    output logic lim_fault
);

    if (LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES >= (2 ** LK_W)) begin : g_bad_lk
        $error("door_input_conditioner: LOCKOUT_CYCLES out of range for LK_W");
    end

    logic btn_db, up_db, dn_db, both_lim;

    sig_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_btn_db (
        .clk     (clk),
        .rst     (rst),
        .din_raw (btn_raw),
        .dout    (btn_db)
    );

    sig_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_up_db (
        .clk     (clk),
        .rst     (rst),
        .din_raw (up_lim_raw),
        .dout    (up_db)
    );

    sig_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_dn_db (
        .clk     (clk),
        .rst     (rst),
        .din_raw (dn_lim_raw),
        .dout    (dn_db)
    );

    assign UP_max   = up_db;
    assign DN_max   = dn_db;
    assign both_lim = up_db & dn_db;

    btn_state_t state_q, state_d;
    logic       act_q, act_d;
    logic       fault_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BTN_IDLE;
            act_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            fault_q <= both_lim;
        end
    end

`ifdef DOOR_ACT_LOCKOUT_EN
    logic [LK_W-1:0] lk_cnt_q, lk_cnt_d;
    logic            lk_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lk_cnt_q <= '0;
        end else begin
            lk_cnt_q <= lk_cnt_d;
        end
    end

    // Saturates at LOCKOUT_CYCLES so the window stays expired until the next pulse.
    always_comb begin
        lk_cnt_d = lk_cnt_q;
        if (act_d) begin
            lk_cnt_d = '0;
        end else if (lk_cnt_q < LK_W'(LOCKOUT_CYCLES)) begin
            lk_cnt_d = lk_cnt_q + 1'b1;
        end
    end

    assign lk_done = (lk_cnt_q >= LK_W'(LOCKOUT_CYCLES));
`endif

    // A press seen during a limit fault still advances the FSM, so it is consumed without a pulse.
    always_comb begin
        state_d = state_q;
        act_d   = 1'b0;
        case (state_q)
            BTN_IDLE: begin
                if (btn_db) begin
                    state_d = BTN_PRESSED;
                    act_d   = !(fault_q || both_lim);
                end
            end
            BTN_PRESSED: begin
                if (!btn_db) begin
`ifdef DOOR_ACT_LOCKOUT_EN
                    state_d = BTN_LOCKOUT;
`else
                    state_d = BTN_IDLE;
`endif
                end
            end
`ifdef DOOR_ACT_LOCKOUT_EN
            BTN_LOCKOUT: begin
                if (lk_done && !btn_db) begin
                    state_d = BTN_IDLE;
                end
            end
`endif
            default: state_d = BTN_IDLE;
        endcase
    end

    assign activate  = act_q;
    assign lim_fault = fault_q;

endmodule
